// File: rtl/vga_scan_controller.sv
// VGA scan controller: generates raster timing, walks the renderer pixel
// address, and registers the returned pixel with sync/blank so that every
// DAC-side output refers to the same pixel.
module vga_scan_controller #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int PIXEL_LATENCY   = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [23:0] iPixel,
  output logic [18:0] oAddress,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oBlankN,
  output logic        oFrameStart
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
  localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
  localparam logic [HW-1:0] HS_START   = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [18:0]   ADDR_LAST  = 19'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic          SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

  logic [HW-1:0] h;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v;
  logic [VW-1:0] v_next;
  logic          started;
  logic          next_origin;
  logic          next_visible;

  logic          visible;
  logic          hs_active;
  logic          vs_active;

  // {visible, hs, vs} per stage
  logic [2:0]    flag_pipe [PIXEL_LATENCY];
  logic [2:0]    flag_out;

  // Next scan position; the first clock out of reset presents (0,0) itself
  // rather than advancing, so the counters can simply be cleared in reset.
  always_comb begin
    h_next = h;
    v_next = v;
    if (!started) begin
      h_next = '0;
      v_next = '0;
    end else if (h == H_LAST) begin
      h_next = '0;
      v_next = (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h_next = h + 1'b1;
    end
    next_origin  = (h_next == '0) && (v_next == '0);
    next_visible = (h_next < H_VIS_END) && (v_next < V_VIS_END);
  end

  // Scan counters, incremental pixel address and frame-start pulse.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      h           <= '0;
      v           <= '0;
      started     <= 1'b0;
      oAddress    <= ADDR_LAST;
      oFrameStart <= 1'b0;
    end else begin
      started     <= 1'b1;
      h           <= h_next;
      v           <= v_next;
      oFrameStart <= next_origin;
      if (next_origin) begin
        oAddress <= '0;
      end else if (next_visible) begin
        oAddress <= oAddress + 1'b1;
      end
    end
  end

  // Timing flags decoded for the position currently on oAddress.
  always_comb begin
    visible   = started && (h < H_VIS_END) && (v < V_VIS_END);
    hs_active = started && (h >= HS_START) && (h < HS_END);
    vs_active = started && (v >= VS_START) && (v < VS_END);
  end

  // Delay flags by the renderer latency so they meet the returned pixel.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int unsigned i = 0; i < PIXEL_LATENCY; i++) begin
        flag_pipe[i] <= '0;
      end
    end else begin
      flag_pipe[0] <= {visible, hs_active, vs_active};
      for (int unsigned i = 1; i < PIXEL_LATENCY; i++) begin
        flag_pipe[i] <= flag_pipe[i-1];
      end
    end
  end

  assign flag_out = flag_pipe[PIXEL_LATENCY-1];

  // Output register: pixel, blank and syncs all launched on one edge.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      oRed    <= '0;
      oGreen  <= '0;
      oBlue   <= '0;
      oBlankN <= 1'b0;
      oHSync  <= SYNC_IDLE;
      oVSync  <= SYNC_IDLE;
    end else begin
      oBlankN <= flag_out[2];
      {oRed, oGreen, oBlue} <= flag_out[2] ? iPixel : '0;
      oHSync  <= flag_out[1] ^ SYNC_IDLE;
      oVSync  <= flag_out[0] ^ SYNC_IDLE;
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller on a reduced raster so whole frames fit in
// a short run; a second instance covers active-high sync polarity.
module tb_vga_scan_controller;

  localparam int HV = 16, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int LAT   = 2;
  localparam int HT    = HV + HF + HS + HB;
  localparam int VT    = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int MAXA  = HV * VV - 1;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [23:0] iPixel = '0;
  logic [23:0] rend_d1 = '0;

  logic [18:0] oAddress,  p_oAddress;
  logic [7:0]  oRed,      p_oRed;
  logic [7:0]  oGreen,    p_oGreen;
  logic [7:0]  oBlue,     p_oBlue;
  logic        oHSync,    p_oHSync;
  logic        oVSync,    p_oVSync;
  logic        oBlankN,   p_oBlankN;
  logic        oFrameStart, p_oFrameStart;

  typedef struct {
    logic        vis;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } exp_t;

  exp_t sb[$];
  int   m_h = 0, m_v = 0;
  bit   m_started = 0;
  int   cycle = 0;
  int   checks = 0, errors = 0;

  vga_scan_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIXEL_LATENCY(LAT), .SYNC_ACTIVE_LOW(1)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iPixel(iPixel),
    .oAddress(oAddress), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oHSync(oHSync), .oVSync(oVSync), .oBlankN(oBlankN),
    .oFrameStart(oFrameStart)
  );

  vga_scan_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIXEL_LATENCY(LAT), .SYNC_ACTIVE_LOW(0)
  ) dut_pos (
    .iClock(iClock), .iReset(iReset), .iPixel(iPixel),
    .oAddress(p_oAddress), .oRed(p_oRed), .oGreen(p_oGreen), .oBlue(p_oBlue),
    .oHSync(p_oHSync), .oVSync(p_oVSync), .oBlankN(p_oBlankN),
    .oFrameStart(p_oFrameStart)
  );

  always #5 iClock = ~iClock;

  // Renderer model: returns {5'b0, address} two clocks after the address.
  always @(posedge iClock) begin
    rend_d1 <= {5'b0, oAddress};
    iPixel  <= rend_d1;
  end

  // One clock: drive reset, advance the reference raster, check the
  // address side now and the DAC side against the entry from LAT+1 ago.
  task automatic tick(input logic rst);
    exp_t        e;
    exp_t        o;
    exp_t        blank;
    logic [18:0] ea;
    logic        efs;
    iReset = rst;
    @(posedge iClock);
    #1;
    cycle++;
    if (rst) begin
      m_started = 0; m_h = 0; m_v = 0;
    end else if (!m_started) begin
      m_started = 1; m_h = 0; m_v = 0;
    end else if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    if (!m_started || m_v >= VV) ea = 19'(MAXA);
    else if (m_h >= HV)          ea = 19'(m_v * HV + HV - 1);
    else                         ea = 19'(m_v * HV + m_h);
    efs   = m_started && m_h == 0 && m_v == 0;
    e.vis = m_started && m_h < HV && m_v < VV;
    e.hs  = m_started && m_h >= HV + HF && m_h < HV + HF + HS;
    e.vs  = m_started && m_v >= VV + VF && m_v < VV + VF + VS;
    e.pix = e.vis ? {5'b0, ea} : 24'h0;

    checks++;
    if (oAddress !== ea)
      $display("FAIL address cyc=%0d got %0d exp %0d (h=%0d v=%0d)", cycle, oAddress, ea, m_h, m_v);
    if (oAddress !== ea) errors++;
    checks++;
    if (oFrameStart !== efs) begin
      errors++;
      $display("FAIL frame_start cyc=%0d got %b exp %b", cycle, oFrameStart, efs);
    end
    checks++;
    if (p_oAddress !== ea || p_oFrameStart !== efs) begin
      errors++;
      $display("FAIL pos_address cyc=%0d got %0d/%b exp %0d/%b", cycle, p_oAddress, p_oFrameStart, ea, efs);
    end

    if (rst) begin
      blank.vis = 0; blank.hs = 0; blank.vs = 0; blank.pix = '0;
      sb.delete();
      for (int i = 0; i < LAT + 1; i++) sb.push_back(blank);
    end
    sb.push_back(e);
    if (sb.size() > LAT + 1) begin
      o = sb.pop_front();
      checks++;
      if ({oRed, oGreen, oBlue} !== o.pix || oBlankN !== o.vis) begin
        errors++;
        $display("FAIL pixel cyc=%0d got rgb=%06h blankn=%b exp rgb=%06h blankn=%b",
                 cycle, {oRed, oGreen, oBlue}, oBlankN, o.pix, o.vis);
      end
      checks++;
      if (oHSync !== ~o.hs || oVSync !== ~o.vs) begin
        errors++;
        $display("FAIL sync_low cyc=%0d got hs=%b vs=%b exp hs=%b vs=%b",
                 cycle, oHSync, oVSync, ~o.hs, ~o.vs);
      end
      checks++;
      if (p_oHSync !== o.hs || p_oVSync !== o.vs || p_oBlankN !== o.vis ||
          {p_oRed, p_oGreen, p_oBlue} !== o.pix) begin
        errors++;
        $display("FAIL sync_high cyc=%0d got hs=%b vs=%b blankn=%b exp hs=%b vs=%b blankn=%b",
                 cycle, p_oHSync, p_oVSync, p_oBlankN, o.hs, o.vs, o.vis);
      end
    end
  endtask

  task automatic test_reset();
    repeat (4) tick(1'b1);
    checks++;
    if (oAddress !== 19'(MAXA) || oBlankN !== 1'b0 || oFrameStart !== 1'b0 ||
        oHSync !== 1'b1 || oVSync !== 1'b1 || {oRed, oGreen, oBlue} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state got addr=%0d blankn=%b fs=%b hs=%b vs=%b exp addr=%0d 0 0 1 1",
               oAddress, oBlankN, oFrameStart, oHSync, oVSync, MAXA);
    end
  endtask

  task automatic test_release();
    tick(1'b0);
    checks++;
    if (oAddress !== 19'd0 || oFrameStart !== 1'b1) begin
      errors++;
      $display("FAIL release_t0 got addr=%0d fs=%b exp 0 1", oAddress, oFrameStart);
    end
    tick(1'b0);
    checks++;
    if (oAddress !== 19'd1 || oFrameStart !== 1'b0 || oBlankN !== 1'b0) begin
      errors++;
      $display("FAIL release_t1 got addr=%0d fs=%b blankn=%b exp 1 0 0", oAddress, oFrameStart, oBlankN);
    end
    tick(1'b0);
    checks++;
    if (oBlankN !== 1'b0) begin
      errors++;
      $display("FAIL release_t2 got blankn=%b exp 0", oBlankN);
    end
    tick(1'b0);
    checks++;
    if (oBlankN !== 1'b1 || {oRed, oGreen, oBlue} !== 24'd0) begin
      errors++;
      $display("FAIL release_t3 got blankn=%b rgb=%06h exp 1 000000", oBlankN, {oRed, oGreen, oBlue});
    end
    tick(1'b0);
    checks++;
    if ({oRed, oGreen, oBlue} !== 24'd1) begin
      errors++;
      $display("FAIL release_t4 got rgb=%06h exp 000001", {oRed, oGreen, oBlue});
    end
  endtask

  task automatic test_frames();
    int last_fs, nfs, zeros;
    logic [18:0] maxa;
    int guard = 0;
    while (oFrameStart !== 1'b1 && guard < 2 * FRAME) begin
      tick(1'b0);
      guard++;
    end
    last_fs = cycle; nfs = 1; zeros = 1; maxa = '0;
    repeat (3 * FRAME) begin
      tick(1'b0);
      if (oAddress == 19'd0) zeros++;
      if (oAddress > maxa) maxa = oAddress;
      if (oFrameStart === 1'b1) begin
        checks++;
        if (cycle - last_fs != FRAME) begin
          errors++;
          $display("FAIL frame_period got %0d exp %0d", cycle - last_fs, FRAME);
        end
        last_fs = cycle;
        nfs++;
      end
    end
    checks++;
    if (nfs != 4) begin
      errors++;
      $display("FAIL frame_count got %0d exp 4", nfs);
    end
    checks++;
    if (zeros != 4) begin
      errors++;
      $display("FAIL addr_zero_count got %0d exp 4", zeros);
    end
    checks++;
    if (maxa != 19'(MAXA)) begin
      errors++;
      $display("FAIL addr_max got %0d exp %0d", maxa, MAXA);
    end
  endtask

  task automatic test_sync_shape();
    int first_low = -1, run = 0, hs_total = 0, vs_total = 0, p_vs_total = 0;
    bit in_run = 0;
    for (int i = 1; i <= FRAME; i++) begin
      tick(1'b0);
      if (oHSync === 1'b0) begin
        hs_total++;
        if (first_low < 0) begin first_low = i; in_run = 1; end
        if (in_run) run++;
      end else begin
        in_run = 0;
      end
      if (oVSync === 1'b0) vs_total++;
      if (p_oVSync === 1'b1) p_vs_total++;
    end
    checks++;
    if (first_low != HV + HF + LAT + 1) begin
      errors++;
      $display("FAIL hsync_offset got %0d exp %0d", first_low, HV + HF + LAT + 1);
    end
    checks++;
    if (run != HS || hs_total != HS * VT) begin
      errors++;
      $display("FAIL hsync_width got run=%0d total=%0d exp %0d %0d", run, hs_total, HS, HS * VT);
    end
    checks++;
    if (vs_total != VS * HT || p_vs_total != VS * HT) begin
      errors++;
      $display("FAIL vsync_width got low=%0d high=%0d exp %0d", vs_total, p_vs_total, VS * HT);
    end
  endtask

  task automatic test_mid_reset(input int rh, input int rv);
    int guard = 0;
    while (!(m_started && m_h == rh && m_v == rv) && guard < 2 * FRAME) begin
      tick(1'b0);
      guard++;
    end
    checks++;
    if (guard >= 2 * FRAME) begin
      errors++;
      $display("FAIL mid_reset_reach got h=%0d v=%0d exp h=%0d v=%0d", m_h, m_v, rh, rv);
    end
    tick(1'b1);
    checks++;
    if (oAddress !== 19'(MAXA) || oBlankN !== 1'b0 || oHSync !== 1'b1 ||
        oVSync !== 1'b1 || oFrameStart !== 1'b0 || {oRed, oGreen, oBlue} !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset got addr=%0d blankn=%b hs=%b vs=%b fs=%b exp %0d 0 1 1 0",
               oAddress, oBlankN, oHSync, oVSync, oFrameStart, MAXA);
    end
    test_release();
    repeat (HT) tick(1'b0);
  endtask

  initial begin
    test_reset();
    test_release();
    test_frames();
    test_sync_shape();
    test_mid_reset(7, 3);
    test_mid_reset(HV + HF + 1, VV + VF);
    test_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
